// File: rtl/sub_arb_pkg.sv
// sub_arb_pkg
//   Shared definitions for the round-robin subtractor scheduler.
//   DEF_BIT / DEF_NREQ / DEF_LAT : default operand width, requester count and
//                                  subtractor latency
//   TAG_W                        : tag id width for the default requester count
//   ID_W                         : tag id width wide enough for any legal
//                                  requester count (up to 16)
//   tag_t                        : {valid, id} ownership tag of one in-flight op
//   rr_next()                    : modular increment used for the arbiter pointer
package sub_arb_pkg;

  localparam int DEF_BIT  = 32;
  localparam int DEF_NREQ = 4;
  localparam int DEF_LAT  = 1;
  localparam int TAG_W    = $clog2(DEF_NREQ);
  localparam int ID_W     = 4;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin search over a set of eligible requesters.
//   eligible : one bit per requester that may be granted this cycle
//   ptr      : index where the search starts (highest priority)
//   grant    : one-hot grant, all zero when nothing is eligible
//   g        : index of the granted requester (0 when nothing is granted)
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   g
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Walk from the farthest candidate back to ptr so the nearest eligible
  // requester is the last one written and therefore wins.
  always_comb begin
    grant = '0;
    g     = '0;
    sum   = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        g          = idx;
      end
    end
  end

endmodule

// File: rtl/sub_arbiter.sv
// sub_arbiter
//   Shares one pipelined subtractor among NREQ requesters with round-robin
//   arbitration, a tag pipeline recording the owner of each in-flight
//   operation, and per-requester response registers.
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_valid/req_ready        : per-requester operand handshake
//   req_a/req_b                : packed operands, requester i at [i*BIT +: BIT]
//   rsp_valid/rsp_ready/rsp_c  : per-requester result handshake and data
//   sub_in_valid/sub_a/sub_b   : registered drive to the subtractor
//   sub_out_valid/sub_c        : result coming back from the subtractor
//   err                        : sticky result/tag alignment error
module sub_arbiter
  import sub_arb_pkg::*;
#(
  parameter int BIT  = DEF_BIT,
  parameter int NREQ = DEF_NREQ,
  parameter int LAT  = DEF_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*BIT-1:0] req_a,
  input  logic [NREQ*BIT-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [NREQ*BIT-1:0] rsp_c,
  output logic              sub_in_valid,
  output logic [BIT-1:0]    sub_a,
  output logic [BIT-1:0]    sub_b,
  input  logic              sub_out_valid,
  input  logic [BIT-1:0]    sub_c,
  output logic              err
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   g;
  logic            any_grant;
  logic [NREQ-1:0] rsp_fire;
  tag_t            tags [0:LAT];
  tag_t            out_tag;

  // A requester with a result still outstanding is not eligible, which
  // guarantees its response register can never be overwritten.
  assign eligible = req_valid & ~pend;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .g        (g)
  );

  // Grants are suppressed while reset is asserted so nothing is accepted.
  assign req_ready = rst_n ? grant : '0;
  assign any_grant = |req_ready;
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign out_tag   = tags[LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr  <= '0;
      pend <= '0;
    end else begin
      pend <= (pend & ~rsp_fire) | req_ready;
      if (any_grant) begin
        ptr <= PW'(rr_next(int'(g), NREQ));
      end
    end
  end

  // Issue register and tag pipeline; the subtractor never stalls, so the
  // tags simply shift every cycle and stage LAT lines up with its output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_in_valid <= 1'b0;
      sub_a        <= '0;
      sub_b        <= '0;
      for (int k = 0; k <= LAT; k++) begin
        tags[k] <= '0;
      end
    end else begin
      sub_in_valid  <= any_grant;
      tags[0].valid <= any_grant;
      tags[0].id    <= ID_W'(g);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          sub_a <= req_a[i*BIT +: BIT];
          sub_b <= req_b[i*BIT +: BIT];
        end
      end
      for (int k = 1; k <= LAT; k++) begin
        tags[k] <= tags[k-1];
      end
    end
  end

  // Writeback: results are only accepted when the aligned tag agrees that an
  // operation is due; any disagreement drops the result and latches err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_c     <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid & ~rsp_fire;
      if (sub_out_valid && out_tag.valid) begin
        for (int i = 0; i < NREQ; i++) begin
          if (out_tag.id == ID_W'(i)) begin
            rsp_valid[i]          <= 1'b1;
            rsp_c[i*BIT +: BIT]   <= sub_c;
          end
        end
      end
      if (sub_out_valid != out_tag.valid) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sub_arbiter.sv
// tb_sub_arbiter
//   Randomized and directed bench for sub_arbiter. A behavioural subtractor
//   sits next to the DUT; a cycle-level reference model predicts grants,
//   response timing and data, and a per-requester scoreboard queue holds the
//   expected results that the monitor pops on each response handshake.
module tb_sub_arbiter;

  localparam int BIT  = 32;
  localparam int NREQ = 4;
  localparam int LAT  = 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*BIT-1:0] req_a = '0;
  logic [NREQ*BIT-1:0] req_b = '0;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready = '0;
  logic [NREQ*BIT-1:0] rsp_c;
  logic                sub_in_valid;
  logic [BIT-1:0]      sub_a;
  logic [BIT-1:0]      sub_b;
  logic                sub_out_valid;
  logic [BIT-1:0]      sub_c;
  logic                err;
  logic                inject = 1'b0;

  int checks = 0;
  int errors = 0;

  sub_arbiter #(
    .BIT  (BIT),
    .NREQ (NREQ),
    .LAT  (LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_c         (rsp_c),
    .sub_in_valid  (sub_in_valid),
    .sub_a         (sub_a),
    .sub_b         (sub_b),
    .sub_out_valid (sub_out_valid),
    .sub_c         (sub_c),
    .err           (err)
  );

  initial forever #5 clk = ~clk;

  // Behavioural subtractor with LAT cycles of latency, sharing rst_n.
  logic [LAT:1]   sv_pipe;
  logic [BIT-1:0] sc_pipe [1:LAT];

  always @(posedge clk) begin
    if (!rst_n) begin
      sv_pipe <= '0;
    end else begin
      sv_pipe[1] <= sub_in_valid;
      sc_pipe[1] <= sub_a - sub_b;
      for (int k = 2; k <= LAT; k++) begin
        sv_pipe[k] <= sv_pipe[k-1];
        sc_pipe[k] <= sc_pipe[k-1];
      end
    end
  end

  assign sub_out_valid = sv_pipe[LAT] | inject;
  assign sub_c         = sc_pipe[LAT];

  task automatic checkOutput(input string name,
                             input logic [NREQ*BIT-1:0] actual,
                             input logic [NREQ*BIT-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  // Reference model state: one outstanding operation per requester, the
  // cycle its response becomes visible, and the last value written back.
  int                  cyc = 0;
  logic [NREQ-1:0]     m_pend = '0;
  int                  m_ready_at [NREQ];
  logic [BIT-1:0]      m_val [NREQ];
  logic [BIT-1:0]      m_rsp_c [NREQ];
  int                  m_ptr = 0;
  logic                m_err = 1'b0;
  logic                m_siv = 1'b0;
  logic [BIT-1:0]      m_sa = '0;
  logic [BIT-1:0]      m_sb = '0;
  logic [BIT-1:0]      exp_q [NREQ][$];

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      m_ready_at[i] = 0;
      m_val[i]      = '0;
      m_rsp_c[i]    = '0;
    end
  end

  // Monitor: samples on the falling edge, when inputs driven after the
  // rising edge and all DUT outputs have settled.
  initial forever begin
    int gsel;
    logic [NREQ-1:0]     exp_ready;
    logic [NREQ-1:0]     exp_rsp_valid;
    logic [NREQ*BIT-1:0] exp_rsp_c;
    logic                landing;
    logic [BIT-1:0]      popped;
    @(negedge clk);
    gsel      = -1;
    exp_ready = '0;
    if (rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (gsel < 0 && req_valid[i] && !m_pend[i]) gsel = i;
      end
      if (gsel >= 0) exp_ready[gsel] = 1'b1;
    end
    landing = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      exp_rsp_valid[i]         = m_pend[i] && (cyc >= m_ready_at[i]);
      exp_rsp_c[i*BIT +: BIT]  = m_rsp_c[i];
      if (m_pend[i] && (m_ready_at[i] - 1 == cyc)) landing = 1'b1;
    end
    checkOutput("req_ready", {{(NREQ*BIT-NREQ){1'b0}}, req_ready}, {{(NREQ*BIT-NREQ){1'b0}}, exp_ready});
    checkOutput("rsp_valid", {{(NREQ*BIT-NREQ){1'b0}}, rsp_valid}, {{(NREQ*BIT-NREQ){1'b0}}, exp_rsp_valid});
    checkOutput("rsp_c", rsp_c, exp_rsp_c);
    checkOutput("sub_in_valid", (NREQ*BIT)'(sub_in_valid), (NREQ*BIT)'(m_siv));
    checkOutput("sub_a", (NREQ*BIT)'(sub_a), (NREQ*BIT)'(m_sa));
    checkOutput("sub_b", (NREQ*BIT)'(sub_b), (NREQ*BIT)'(m_sb));
    checkOutput("err", (NREQ*BIT)'(err), (NREQ*BIT)'(m_err));

    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (exp_rsp_valid[i] && rsp_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            checkOutput("scoreboard_empty", '0, '1);
          end else begin
            popped = exp_q[i].pop_front();
            checkOutput("rsp_data", (NREQ*BIT)'(rsp_c[i*BIT +: BIT]), (NREQ*BIT)'(popped));
          end
        end
      end
    end

    if (!rst_n) begin
      m_pend = '0;
      m_ptr  = 0;
      m_err  = 1'b0;
      m_siv  = 1'b0;
      m_sa   = '0;
      m_sb   = '0;
      for (int i = 0; i < NREQ; i++) begin
        m_rsp_c[i] = '0;
        exp_q[i].delete();
      end
    end else begin
      if (inject && !landing) m_err = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (m_pend[i] && (cyc + 1 == m_ready_at[i])) m_rsp_c[i] = m_val[i];
        if (exp_rsp_valid[i] && rsp_ready[i]) m_pend[i] = 1'b0;
      end
      if (gsel >= 0) begin
        m_pend[gsel]     = 1'b1;
        m_ready_at[gsel] = cyc + 2 + LAT;
        m_val[gsel]      = req_a[gsel*BIT +: BIT] - req_b[gsel*BIT +: BIT];
        exp_q[gsel].push_back(m_val[gsel]);
        m_ptr = (gsel + 1) % NREQ;
        m_siv = 1'b1;
        m_sa  = req_a[gsel*BIT +: BIT];
        m_sb  = req_b[gsel*BIT +: BIT];
      end else begin
        m_siv = 1'b0;
      end
    end
    cyc++;
  end

  // Applies one cycle worth of inputs just after the rising edge.
  task automatic applyStimulus(input logic rst_v,
                               input logic [NREQ-1:0] valid_v,
                               input logic [NREQ-1:0] ready_v,
                               input logic [NREQ*BIT-1:0] a_v,
                               input logic [NREQ*BIT-1:0] b_v,
                               input logic inj_v);
    @(posedge clk);
    #1;
    rst_n     = rst_v;
    req_valid = valid_v;
    rsp_ready = ready_v;
    req_a     = a_v;
    req_b     = b_v;
    inject    = inj_v;
  endtask

  task automatic idle(input int n, input logic [NREQ-1:0] ready_v);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, '0, ready_v, '0, '0, 1'b0);
  endtask

  function automatic logic [NREQ*BIT-1:0] rand_ops();
    logic [NREQ*BIT-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i*BIT +: BIT] = $urandom;
    return v;
  endfunction

  initial begin
    logic [NREQ*BIT-1:0] a_v;
    logic [NREQ*BIT-1:0] b_v;
    logic [NREQ-1:0]     rdy;

    $display("[TB] start");
    repeat (3) applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);

    // Single request from requester 0: 5 - 3.
    a_v = '0; b_v = '0;
    a_v[0*BIT +: BIT] = 32'd5;
    b_v[0*BIT +: BIT] = 32'd3;
    applyStimulus(1'b1, 4'b0001, '1, a_v, b_v, 1'b0);
    idle(6, '1);

    // Two's-complement wrap on requester 2.
    a_v = '0; b_v = '0;
    b_v[2*BIT +: BIT] = 32'd1;
    applyStimulus(1'b1, 4'b0100, '1, a_v, b_v, 1'b0);
    idle(6, '1);
    a_v[2*BIT +: BIT] = 32'h8000_0000;
    applyStimulus(1'b1, 4'b0100, '1, a_v, b_v, 1'b0);
    idle(6, '1);

    // Everyone at once with (10+i) - i, responses always accepted.
    for (int i = 0; i < NREQ; i++) begin
      a_v[i*BIT +: BIT] = BIT'(10 + i);
      b_v[i*BIT +: BIT] = BIT'(i);
    end
    repeat (24) applyStimulus(1'b1, '1, '1, a_v, b_v, 1'b0);
    idle(6, '1);

    // Backpressure on requester 1 while all keep requesting.
    repeat (30) applyStimulus(1'b1, '1, 4'b1101, rand_ops(), rand_ops(), 1'b0);
    idle(6, '1);

    // Reset with operations in flight.
    repeat (3) applyStimulus(1'b1, '1, 4'b0000, rand_ops(), rand_ops(), 1'b0);
    applyStimulus(1'b0, '1, '1, rand_ops(), rand_ops(), 1'b0);
    idle(6, '1);

    // Long randomized run with occasional resets.
    for (int n = 0; n < 1200; n++) begin
      for (int i = 0; i < NREQ; i++) rdy[i] = ($urandom_range(0, 3) != 0);
      applyStimulus(($urandom_range(0, 199) != 0), NREQ'($urandom), rdy,
                    rand_ops(), rand_ops(), 1'b0);
    end
    idle(10, '1);
    for (int i = 0; i < NREQ; i++) begin
      checkOutput("drain_q", (NREQ*BIT)'(exp_q[i].size()), '0);
    end

    // Spurious result with nothing in flight, then reset clears err.
    applyStimulus(1'b1, '0, '1, '0, '0, 1'b1);
    idle(5, '1);
    applyStimulus(1'b0, '0, '1, '0, '0, 1'b0);
    idle(4, '1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
